dt_res_packer: RTL and testbench
================================

Name: dt_res_packer

Overview:
- Reads a finished 128x128 distance map from the 8-bit result RAM and thresholds each pixel.
- Packs 16 pixels per word into the 16-bit-wide binary image format and writes the words to a 1024-word image memory.
- It is the encoder for the DT input side: with thresh=1, it regenerates the original binary image from a distance map, which enables round-trip checking.

Parameters:
- RES_AW, 14, result-memory address width (16384 pixels).
- PK_AW, 10, packed-memory address width (1024 words).
- PIX_W, 8, pixel/distance width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle request to begin a pass.
- thresh  in  8  pixel-set threshold, sampled on accepted start.
- busy  out  1  high from accepted start through the done cycle.
- done  out  1  one-cycle pulse at end of pass.
- res_rd  out  1  result-memory read strobe.
- res_addr  out  14  result-memory read address.
- res_di  in  8  read data, valid the cycle after res_rd.
- pk_wr  out  1  packed-memory write strobe.
- pk_addr  out  10  packed-memory word address.
- pk_do  out  [0:15]  packed word; index 0 = lowest pixel address.
- ones_cnt  out  15  count of set pixels in the last pass.

Behaviour:
- Reset (async, active-low): all outputs are 0 (busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_do, ones_cnt). State returns to IDLE and the internal shift register and counters clear. Reset mid-pass aborts the pass with no further writes.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches thresh, clears ones_cnt, and moves to RUN. start while busy is ignored.
  - RUN: res_rd=1 every cycle. res_addr begins at 0 in the first RUN cycle and increments by 1 each cycle. After the cycle with res_addr=16383, the FSM goes to DRAIN. res_addr stays at 16383 and does not wrap.
  - DRAIN: res_rd=0 and lasts 2 cycles, enough to flush the read latency and the final write.
  - DONE: done=1 for one cycle, then IDLE.
- Pixel rule: bit = (res_di >= thresh_latched), an unsigned 8-bit compare. thresh=0 makes every bit 1. thresh=255 sets only pixels with value 255.
- Capture timing: res_di is valid the cycle after res_rd. The bit for address a is shifted in at the end of that cycle into position a[3:0].
- Write timing: pk_wr=1 for one cycle, two cycles after the res_addr cycle whose a[3:0]=15, with pk_addr=a[13:4] and the complete word on pk_do.
  - Exactly 1024 writes per pass, one every 16 cycles, in ascending pk_addr.
  - pk_addr and pk_do hold their values between writes.
- ones_cnt increments by 1 per set bit. It is stable and valid when done pulses (0..16384, so 15 bits) and holds until the next accepted start.
- Latency: with start sampled at edge 0, RUN covers cycles 1..16384, the last pk_wr is at cycle 16386, and done is at cycle 16387. busy is high on cycles 1..16387.
- No backpressure: the downstream memory accepts a write every cycle.

Decomposition:
- Package dt_pkg:
  - constants IMG_PIXELS=16384, IMG_WORDS=1024, PACK_W=16, RES_AW, PK_AW, PIX_W;
  - state enumeration for IDLE/RUN/DRAIN/DONE.
- Sub-module dt_bit_packer:
  - inputs: bit_valid, bit, bit_idx[3:0], word_idx[9:0];
  - outputs: pk_wr, pk_addr, pk_do;
  - owns the 16-bit shift/insert register and the one-cycle write strobe.
- The top level owns the FSM, address counter, threshold latch and ones_cnt.

Test Plan:
- All-zero map, thresh=1 -> 1024 writes, each pk_do=16'h0000 with pk_addr 0..1023 in order; ones_cnt=0; done at cycle 16387.
- Map with pixel 0=5, others 0, thresh=1 -> word 0 = 16'h8000 (bit index 0 set), other words 0; ones_cnt=1.
- Pixel 17=3, others 0: thresh=4 -> word 1 = 16'h0000, ones_cnt=0; repeat with thresh=3 -> word 1 = 16'h4000, ones_cnt=1.
- Round trip: random binary image -> DT -> packer with thresh=1 -> all 1024 words equal the original image words; ones_cnt equals the original popcount.
- start pulsed again at cycle 500 of a pass -> ignored, still exactly 1024 writes and one done; thresh=0 pass -> every word 16'hFFFF, ones_cnt=16384.
- reset low at cycle 3000 -> outputs immediately 0, no pk_wr afterward; a new start after reset completes a full pass normally.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared constants and the state encoding for the distance-map result packer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dt_pkg;

   localparam int RES_AW     = 14;      // result-memory address width
   localparam int PK_AW      = 10;      // packed-memory address width
   localparam int PIX_W      = 8;       // pixel / distance width
   localparam int PACK_W     = 16;      // pixels per packed word
   localparam int IMG_PIXELS = 16384;   // 128 x 128
   localparam int IMG_WORDS  = 1024;    // IMG_PIXELS / PACK_W

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/dt_bit_packer.sv
// Collects thresholded pixel bits into 16-bit words and emits one write per word.
// Latency: a word is written the cycle after its bit_idx=15 bit is presented.
// Backpressure: none; the downstream memory accepts every write.
//
// Ports:
//   clk, reset          clock, async active-low reset
//   bit_valid, pix_bit  one pixel bit per cycle when bit_valid is high
//   bit_idx, word_idx   position of that bit inside the image (pixel addr [3:0] / [13:4])
//   pk_wr, pk_addr, pk_do  registered write strobe, word address and word (index 0 = lowest pixel)
module dt_bit_packer
   import dt_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_valid,
   input  logic              pix_bit,
   input  logic [3:0]        bit_idx,
   input  logic [PK_AW-1:0]  word_idx,
   output logic              pk_wr,
   output logic [PK_AW-1:0]  pk_addr,
   output logic [0:PACK_W-1] pk_do
);

   logic [0:PACK_W-1] shreg;
   logic [0:PACK_W-1] shreg_nxt;

   // Insert by position rather than shifting: every slot is rewritten once per
   // word, so no clearing is needed between words.
   always_comb begin
      shreg_nxt          = shreg;
      shreg_nxt[bit_idx] = pix_bit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg   <= '0;
         pk_wr   <= 1'b0;
         pk_addr <= '0;
         pk_do   <= '0;
      end else begin
         pk_wr <= 1'b0;
         if (bit_valid) begin
            shreg <= shreg_nxt;
            // Last bit of a word: publish the completed word including this bit.
            if (bit_idx == 4'(PACK_W - 1)) begin
               pk_wr   <= 1'b1;
               pk_addr <= word_idx;
               pk_do   <= shreg_nxt;
            end
         end
      end
   end

endmodule

// File: rtl/dt_res_packer.sv
// Thresholds a 128x128 distance map from the result RAM and packs it into 1024 16-bit words.
// Latency: start at edge 0 -> reads on cycles 1..16384, last write cycle 16386, done cycle 16387.
// Backpressure: none; one read per cycle, writes are never stalled.
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   start, thresh              pass request; thresh is latched when start is accepted
//   busy, done                 pass in progress / one-cycle end-of-pass pulse
//   res_rd, res_addr, res_di   result-memory read port (data one cycle after res_rd)
//   pk_wr, pk_addr, pk_do      packed-image write port
//   ones_cnt                   number of set pixels in the last pass
module dt_res_packer
   import dt_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [PIX_W-1:0]  thresh,
   output logic              busy,
   output logic              done,
   output logic              res_rd,
   output logic [RES_AW-1:0] res_addr,
   input  logic [PIX_W-1:0]  res_di,
   output logic              pk_wr,
   output logic [PK_AW-1:0]  pk_addr,
   output logic [0:PACK_W-1] pk_do,
   output logic [RES_AW:0]   ones_cnt
);

   localparam logic [RES_AW-1:0] LAST_ADDR = '1;

   state_t            state;
   logic              drain_last;
   logic [PIX_W-1:0]  thresh_q;

   // Read-request pipeline: tags the returning res_di with its pixel address.
   logic              rd_d;
   logic [RES_AW-1:0] addr_d;
   logic              pix_bit;

   assign pix_bit = (res_di >= thresh_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_d   <= 1'b0;
         addr_d <= '0;
      end else begin
         rd_d   <= res_rd;
         addr_d <= res_addr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         res_rd     <= 1'b0;
         res_addr   <= '0;
         thresh_q   <= '0;
         drain_last <= 1'b0;
         ones_cnt   <= '0;
      end else begin
         // The last bit arrives during DRAIN, so counting never overlaps the
         // clear done on an accepted start.
         if (rd_d && pix_bit)
            ones_cnt <= ones_cnt + (RES_AW + 1)'(1);
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_RUN;
                  busy     <= 1'b1;
                  res_rd   <= 1'b1;
                  res_addr <= '0;
                  thresh_q <= thresh;
                  ones_cnt <= '0;
               end
            end
            ST_RUN: begin
               if (res_addr == LAST_ADDR) begin
                  // Address parks on the last pixel rather than wrapping.
                  state      <= ST_DRAIN;
                  res_rd     <= 1'b0;
                  drain_last <= 1'b0;
               end else begin
                  res_addr <= res_addr + RES_AW'(1);
               end
            end
            ST_DRAIN: begin
               // Two cycles: one for the read latency, one for the final write.
               if (drain_last) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  drain_last <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   dt_bit_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .bit_valid (rd_d),
      .pix_bit   (pix_bit),
      .bit_idx   (addr_d[3:0]),
      .word_idx  (addr_d[RES_AW-1:4]),
      .pk_wr     (pk_wr),
      .pk_addr   (pk_addr),
      .pk_do     (pk_do)
   );

endmodule

// File: tb/tb_dt_res_packer.sv
// Testbench for dt_res_packer: result-RAM model plus a pixel-rule reference model.
// Latency: expects done 16387 cycles after the start edge.
// Backpressure: none exercised; the DUT has none.
module tb_dt_res_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  thresh;
   logic        busy;
   logic        done;
   logic        res_rd;
   logic [13:0] res_addr;
   logic [7:0]  res_di;
   logic        pk_wr;
   logic [9:0]  pk_addr;
   logic [0:15] pk_do;
   logic [14:0] ones_cnt;

   logic [15:0] pk_flat;
   assign pk_flat = pk_do;   // pk_do[0] (lowest pixel) lands on pk_flat[15]

   dt_res_packer dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .thresh   (thresh),
      .busy     (busy),
      .done     (done),
      .res_rd   (res_rd),
      .res_addr (res_addr),
      .res_di   (res_di),
      .pk_wr    (pk_wr),
      .pk_addr  (pk_addr),
      .pk_do    (pk_do),
      .ones_cnt (ones_cnt)
   );

   always #5 clk = ~clk;

   // Result RAM: synchronous read, data valid the cycle after res_rd.
   logic [7:0] res_mem [0:16383];
   initial res_di = 8'h00;
   always @(posedge clk) if (res_rd) res_di <= res_mem[res_addr];

   int checks = 0;
   int errors = 0;

   // Reference model output
   logic [15:0] exp_word [0:1023];
   int          exp_ones;

   // Observations of one pass
   int          wr_cnt;
   logic [9:0]  wr_addr [0:1023];
   logic [15:0] wr_dat  [0:1023];
   int          wr_cyc  [0:1023];
   int          done_cnt, done_cyc, busy_bad, seq_bad;
   logic [14:0] ones_at_done, ones_at_end;

   // Pixel rule from first principles: pixel p belongs to word p/16, slot p%16,
   // slot 0 being the most significant bit of the 16-bit word.
   task automatic build_model(input logic [7:0] th);
      exp_ones = 0;
      for (int w = 0; w < 1024; w++) begin
         exp_word[w] = 16'h0000;
         for (int i = 0; i < 16; i++) begin
            if (res_mem[w*16 + i] >= th) begin
               exp_word[w][15-i] = 1'b1;
               exp_ones++;
            end
         end
      end
   endtask

   task automatic fill_map(input logic [7:0] v);
      for (int p = 0; p < 16384; p++) res_mem[p] = v;
   endtask

   // Drives one full pass and records everything observed on cycles 1..16400.
   task automatic run_pass(input logic [7:0] th, input int restart_at, input logic [7:0] rth);
      logic [9:0]  last_addr;
      logic [15:0] last_dat;
      wr_cnt = 0; done_cnt = 0; done_cyc = 0; busy_bad = 0; seq_bad = 0;
      ones_at_done = '0;
      last_addr = '0; last_dat = '0;
      @(negedge clk); start = 1'b1; thresh = th;
      @(negedge clk); start = 1'b0; thresh = 8'($urandom);
      for (int n = 1; n <= 16400; n++) begin
         if (busy !== (n <= 16387)) busy_bad++;
         if (n <= 16384) begin
            if (res_rd !== 1'b1 || res_addr !== 14'(n - 1)) seq_bad++;
         end else if (res_rd !== 1'b0) seq_bad++;
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc     = n;
            ones_at_done = ones_cnt;
         end
         if (pk_wr === 1'b1) begin
            if (wr_cnt < 1024) begin
               wr_addr[wr_cnt] = pk_addr;
               wr_dat[wr_cnt]  = pk_flat;
               wr_cyc[wr_cnt]  = n;
            end
            wr_cnt++;
            last_addr = pk_addr;
            last_dat  = pk_flat;
         end else if (wr_cnt > 0 && (pk_addr !== last_addr || pk_flat !== last_dat)) begin
            seq_bad++;
         end
         start = (n == restart_at);
         if (n == restart_at) thresh = rth;
         @(negedge clk);
      end
      start = 1'b0;
      ones_at_end = ones_cnt;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; thresh = 8'h00;
      #1;
      checks++;
      if ({busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_flat, ones_cnt} !== '0)
         $display("FAIL reset_outputs: got busy=%b done=%b rd=%b addr=%0d wr=%b pka=%0d pkd=%h ones=%0d want all 0",
                  busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_flat, ones_cnt);
      if ({busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_flat, ones_cnt} !== '0) errors++;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || res_rd !== 1'b0 || pk_wr !== 1'b0) begin
         $display("FAIL idle_quiet: got busy=%b rd=%b wr=%b want 0 0 0", busy, res_rd, pk_wr);
         errors++;
      end
   endtask

   task automatic test_abort();
      int wr_n, bad;
      logic [7:0] th;
      for (int p = 0; p < 16384; p++) res_mem[p] = 8'($urandom);
      th = 8'($urandom_range(1, 254));
      build_model(th);
      wr_n = 0; bad = 0;
      @(negedge clk); start = 1'b1; thresh = th;
      @(negedge clk); start = 1'b0;
      for (int n = 1; n <= 3000; n++) begin
         if (pk_wr === 1'b1) begin
            if (pk_addr !== 10'(wr_n) || pk_flat !== exp_word[wr_n] || n !== 16*wr_n + 18) bad++;
            wr_n++;
         end
         if (n < 3000) @(negedge clk);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, res_rd, res_addr, pk_wr, pk_addr, pk_flat, ones_cnt} !== '0) begin
         $display("FAIL abort_outputs: got busy=%b rd=%b addr=%0d wr=%b pka=%0d pkd=%h ones=%0d want all 0",
                  busy, res_rd, res_addr, pk_wr, pk_addr, pk_flat, ones_cnt);
         errors++;
      end
      checks++;
      if (wr_n !== 187 || bad !== 0) begin
         $display("FAIL abort_prefix: got %0d writes (%0d bad) want 187 writes (0 bad)", wr_n, bad);
         errors++;
      end
      repeat (4) @(negedge clk);
      reset = 1'b1;
      wr_n = 0; bad = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (pk_wr === 1'b1) wr_n++;
         if (busy !== 1'b0 || done !== 1'b0 || res_rd !== 1'b0) bad++;
      end
      checks++;
      if (wr_n !== 0 || bad !== 0) begin
         $display("FAIL abort_silence: got %0d writes, %0d active cycles want 0 0", wr_n, bad);
         errors++;
      end
   endtask

   task automatic test_single_pixel(input logic [7:0] th);
      int bad;
      logic [15:0] want1;
      fill_map(8'h00);
      res_mem[0]  = 8'd5;
      res_mem[17] = 8'd3;
      build_model(th);
      run_pass(th, 0, 8'h00);
      bad = 0;
      for (int k = 0; k < wr_cnt && k < 1024; k++)
         if (wr_addr[k] !== 10'(k) || wr_dat[k] !== exp_word[k] || wr_cyc[k] !== 16*k + 18) bad++;
      checks++;
      if (wr_cnt !== 1024 || bad !== 0) begin
         $display("FAIL pixel_th%0d_words: got %0d writes (%0d bad) want 1024 (0 bad)", th, wr_cnt, bad);
         errors++;
      end
      checks++;
      if (wr_dat[0] !== 16'h8000) begin
         $display("FAIL pixel_th%0d_word0: got %h want 8000", th, wr_dat[0]);
         errors++;
      end
      want1 = (th <= 8'd3) ? 16'h4000 : 16'h0000;
      checks++;
      if (wr_dat[1] !== want1) begin
         $display("FAIL pixel_th%0d_word1: got %h want %h", th, wr_dat[1], want1);
         errors++;
      end
      checks++;
      if (ones_at_done !== 15'(exp_ones) || ones_at_end !== 15'(exp_ones)) begin
         $display("FAIL pixel_th%0d_ones: got %0d/%0d want %0d", th, ones_at_done, ones_at_end, exp_ones);
         errors++;
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== 16387 || busy_bad !== 0 || seq_bad !== 0) begin
         $display("FAIL pixel_th%0d_timing: got done x%0d at %0d, busy_bad=%0d seq_bad=%0d want x1 at 16387, 0, 0",
                  th, done_cnt, done_cyc, busy_bad, seq_bad);
         errors++;
      end
   endtask

   task automatic test_round_trip();
      logic [15:0] img [0:1023];
      int pop, bad;
      pop = 0;
      for (int w = 0; w < 1024; w++) begin
         img[w] = 16'($urandom);
         pop += $countones(img[w]);
         for (int i = 0; i < 16; i++)
            res_mem[w*16 + i] = img[w][15-i] ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      run_pass(8'd1, 0, 8'h00);
      bad = 0;
      for (int k = 0; k < wr_cnt && k < 1024; k++)
         if (wr_addr[k] !== 10'(k) || wr_dat[k] !== img[k] || wr_cyc[k] !== 16*k + 18) bad++;
      checks++;
      if (wr_cnt !== 1024 || bad !== 0) begin
         $display("FAIL round_trip_words: got %0d writes (%0d bad) want 1024 (0 bad)", wr_cnt, bad);
         errors++;
      end
      checks++;
      if (ones_at_done !== 15'(pop)) begin
         $display("FAIL round_trip_ones: got %0d want %0d", ones_at_done, pop);
         errors++;
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== 16387 || busy_bad !== 0 || seq_bad !== 0) begin
         $display("FAIL round_trip_timing: got done x%0d at %0d, busy_bad=%0d seq_bad=%0d want x1 at 16387, 0, 0",
                  done_cnt, done_cyc, busy_bad, seq_bad);
         errors++;
      end
   endtask

   task automatic test_restart_thresh0();
      int bad;
      fill_map(8'h00);
      for (int p = 0; p < 64; p++) res_mem[$urandom_range(0, 16383)] = 8'($urandom);
      build_model(8'h00);
      // A second start with thresh=200 mid-pass must not disturb anything.
      run_pass(8'h00, 500, 8'd200);
      bad = 0;
      for (int k = 0; k < wr_cnt && k < 1024; k++)
         if (wr_addr[k] !== 10'(k) || wr_dat[k] !== exp_word[k] || wr_dat[k] !== 16'hFFFF || wr_cyc[k] !== 16*k + 18) bad++;
      checks++;
      if (wr_cnt !== 1024 || bad !== 0) begin
         $display("FAIL restart_words: got %0d writes (%0d bad) want 1024 of FFFF", wr_cnt, bad);
         errors++;
      end
      checks++;
      if (ones_at_done !== 15'd16384 || ones_at_end !== 15'd16384) begin
         $display("FAIL restart_ones: got %0d/%0d want 16384", ones_at_done, ones_at_end);
         errors++;
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== 16387 || busy_bad !== 0 || seq_bad !== 0) begin
         $display("FAIL restart_timing: got done x%0d at %0d, busy_bad=%0d seq_bad=%0d want x1 at 16387, 0, 0",
                  done_cnt, done_cyc, busy_bad, seq_bad);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_abort();
      test_single_pixel(8'd4);
      test_single_pixel(8'd3);
      test_round_trip();
      test_restart_thresh0();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
